// File: rtl/prog_cntr_sel_ras_if.sv
// Fetch-stage next-address bus: select controls and addresses in, PC and RAS status out.
interface prog_cntr_sel_ras_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int RAS_DEPTH  = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic                  stall;
    logic [2:0]            sel_signals;
    logic [ADDR_WIDTH-1:0] branch_target_addr;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [ADDR_WIDTH-1:0] int_vector_addr;
    logic                  clear_flags;
    logic [ADDR_WIDTH-1:0] prog_cntr;
    logic [ADDR_WIDTH-1:0] prog_cntr_load_val;
    logic [CW-1:0]         ras_count;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ras_overflow;
    logic                  ras_underflow;

    modport master (
        output stall, sel_signals, branch_target_addr, ret_addr, int_vector_addr, clear_flags,
        input  prog_cntr, prog_cntr_load_val, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, sel_signals, branch_target_addr, ret_addr, int_vector_addr, clear_flags,
        output prog_cntr, prog_cntr_load_val, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );
endinterface

// File: rtl/prog_cntr_sel_ras.sv
// Program counter with next-address select and a circular return address stack.
// Define PROG_CNTR_RAS_EN to build the internal RAS; otherwise CALL/INT do not push and RET uses ret_addr.
module prog_cntr_sel_ras #(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    RAS_DEPTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    prog_cntr_sel_ras_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_CALL   = 3'b010;
    localparam logic [2:0] SEL_RET    = 3'b011;
    localparam logic [2:0] SEL_INT    = 3'b100;
    localparam logic [2:0] SEL_HOLD   = 3'b101;

    logic [ADDR_WIDTH-1:0] prog_cntr;
    logic [ADDR_WIDTH-1:0] seq;
    logic [ADDR_WIDTH-1:0] load_val;
    logic [ADDR_WIDTH-1:0] ret_val;

    assign seq = prog_cntr + 1'b1;

    always_comb begin
        load_val = seq;
        if (bus.stall) begin
            load_val = prog_cntr;
        end else begin
            case (bus.sel_signals)
                SEL_SEQ:    load_val = seq;
                SEL_BRANCH: load_val = bus.branch_target_addr;
                SEL_CALL:   load_val = bus.branch_target_addr;
                SEL_RET:    load_val = ret_val;
                SEL_INT:    load_val = bus.int_vector_addr;
                SEL_HOLD:   load_val = prog_cntr;
                default:    load_val = seq;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prog_cntr <= RESET_VECTOR;
        else          prog_cntr <= load_val;
    end

    assign bus.prog_cntr          = prog_cntr;
    assign bus.prog_cntr_load_val = load_val;

`ifdef PROG_CNTR_RAS_EN
    logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]         ptr;      // next slot to write; top of stack is ptr-1
    logic [CW-1:0]         count;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_val;
    logic                  full;

    assign full     = (count == CW'(RAS_DEPTH));
    assign push     = !bus.stall && (bus.sel_signals == SEL_CALL || bus.sel_signals == SEL_INT);
    assign pop      = !bus.stall && (bus.sel_signals == SEL_RET);
    // INT saves the interrupted PC itself so that instruction is re-fetched on return
    assign push_val = (bus.sel_signals == SEL_INT) ? prog_cntr : seq;
    assign ret_val  = (count != '0) ? mem[ptr - 1'b1] : bus.ret_addr;

    always_ff @(posedge clock) begin
        if (push) mem[ptr] <= push_val;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.clear_flags) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            // a push when full overwrites the oldest slot since the buffer is circular
            if (push) begin
                ptr <= ptr + 1'b1;
                if (full) ovf_q <= 1'b1;
                else      count <= count + 1'b1;
            end else if (pop) begin
                if (count != '0) begin
                    ptr   <= ptr - 1'b1;
                    count <= count - 1'b1;
                end else begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ras_count     = count;
    assign bus.ras_empty     = (count == '0);
    assign bus.ras_full      = full;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
`else
    wire unused_clear = bus.clear_flags;

    assign ret_val           = bus.ret_addr;
    assign bus.ras_count     = '0;
    assign bus.ras_empty     = 1'b1;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_overflow  = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prog_cntr_sel_ras.sv
// Directed bench for prog_cntr_sel_ras; expectations follow PROG_CNTR_RAS_EN when it is defined.
module tb_prog_cntr_sel_ras;
`ifdef PROG_CNTR_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    prog_cntr_sel_ras_if #(.ADDR_WIDTH(14), .RAS_DEPTH(8)) bus ();

    prog_cntr_sel_ras #(.ADDR_WIDTH(14), .RAS_DEPTH(8), .RESET_VECTOR(14'h0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [2:0] sel, input logic [13:0] tgt);
        bus.sel_signals        = sel;
        bus.branch_target_addr = tgt;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.stall = 1'b0; bus.sel_signals = 3'b000; bus.clear_flags = 1'b0;
        bus.branch_target_addr = '0; bus.ret_addr = 14'h0ABC; bus.int_vector_addr = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] exp_pc[4] = '{14'h0000, 14'h0001, 14'h0002, 14'h0003};
        do_reset();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.prog_cntr !== 14'h0000 || bus.ras_count !== 4'd0 || bus.ras_empty !== 1'b1 ||
            bus.ras_full !== 1'b0 || bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
            $display("FAIL reset_state pc=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b (want 0000 0 1 0 0 0)",
                     bus.prog_cntr, bus.ras_count, bus.ras_empty, bus.ras_full,
                     bus.ras_overflow, bus.ras_underflow);
            errors++;
        end
        vectors++;
        if (bus.prog_cntr_load_val !== 14'h0001) begin
            $display("FAIL reset_load_val got=%h want=0001", bus.prog_cntr_load_val);
            errors++;
        end
        step();
        reset_n = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            vectors++;
            if (bus.prog_cntr !== exp_pc[i]) begin
                $display("FAIL seq_%0d got=%h want=%h", i, bus.prog_cntr, exp_pc[i]);
                errors++;
            end
        end
    endtask

    task automatic test_wrap();
        set_in(3'b001, 14'h3FFF);
        #1;
        vectors++;
        if (bus.prog_cntr_load_val !== 14'h3FFF) begin
            $display("FAIL branch_load_val got=%h want=3FFF", bus.prog_cntr_load_val);
            errors++;
        end
        step();
        vectors++;
        if (bus.prog_cntr !== 14'h3FFF) begin
            $display("FAIL branch got=%h want=3FFF", bus.prog_cntr);
            errors++;
        end
        set_in(3'b000, 14'h0000);
        step();
        vectors++;
        if (bus.prog_cntr !== 14'h0000) begin
            $display("FAIL seq_wrap got=%h want=0000", bus.prog_cntr);
            errors++;
        end
        // codes 110/111 alias SEQ, HOLD keeps PC
        set_in(3'b110, 14'h1234); step();
        set_in(3'b111, 14'h1234); step();
        set_in(3'b101, 14'h1234); step();
        vectors++;
        if (bus.prog_cntr !== 14'h0002) begin
            $display("FAIL alias_hold got=%h want=0002", bus.prog_cntr);
            errors++;
        end
    endtask

    task automatic test_call_ret();
        logic [13:0] exp_pc[3]  = '{14'h0200, 14'h0201, RAS_EN ? 14'h0011 : 14'h0ABC};
        int          exp_cnt[3] = '{RAS_EN ? 1 : 0, RAS_EN ? 1 : 0, 0};
        logic [2:0]  sel[3]     = '{3'b010, 3'b000, 3'b011};
        do_reset();
        set_in(3'b001, 14'h0010); step();
        for (int i = 0; i < 3; i++) begin
            set_in(sel[i], 14'h0200);
            step();
            vectors++;
            if (bus.prog_cntr !== exp_pc[i] || bus.ras_count !== 4'(exp_cnt[i])) begin
                $display("FAIL call_ret_%0d pc=%h cnt=%0d want pc=%h cnt=%0d",
                         i, bus.prog_cntr, bus.ras_count, exp_pc[i], exp_cnt[i]);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(3'b001, 14'h0100); step();
        set_in(3'b010, 14'h0800); step();
        set_in(3'b011, 14'h0000); step();
        vectors++;
        if (bus.prog_cntr !== (RAS_EN ? 14'h0101 : 14'h0ABC) || bus.ras_empty !== 1'b1) begin
            $display("FAIL b2b_call_ret pc=%h empty=%b want pc=%h empty=1",
                     bus.prog_cntr, bus.ras_empty, RAS_EN ? 14'h0101 : 14'h0ABC);
            errors++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        bus.stall = 1'b1;
        set_in(3'b010, 14'h0300);
        #1;
        vectors++;
        if (bus.prog_cntr_load_val !== 14'h0002) begin
            $display("FAIL stall_load_val got=%h want=0002", bus.prog_cntr_load_val);
            errors++;
        end
        step(); step();
        vectors++;
        if (bus.prog_cntr !== 14'h0002 || bus.ras_count !== 4'd0) begin
            $display("FAIL stall_hold pc=%h cnt=%0d want 0002 0", bus.prog_cntr, bus.ras_count);
            errors++;
        end
        bus.stall = 1'b0;
        step();
        vectors++;
        if (bus.prog_cntr !== 14'h0300 || bus.ras_count !== (RAS_EN ? 4'd1 : 4'd0)) begin
            $display("FAIL stall_release pc=%h cnt=%0d want 0300 %0d",
                     bus.prog_cntr, bus.ras_count, RAS_EN ? 1 : 0);
            errors++;
        end
        set_in(3'b011, 14'h0000); step();
        vectors++;
        if (bus.prog_cntr !== (RAS_EN ? 14'h0003 : 14'h0ABC)) begin
            $display("FAIL stall_ret got=%h want=%h", bus.prog_cntr, RAS_EN ? 14'h0003 : 14'h0ABC);
            errors++;
        end
    endtask

    task automatic test_overflow();
        logic [13:0] tgt, exp;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tgt = 14'h1000 + 14'(i * 16);
            set_in(3'b010, tgt);
            step();
            vectors++;
            if (bus.prog_cntr !== tgt ||
                bus.ras_count !== (RAS_EN ? 4'((i < 8) ? i + 1 : 8) : 4'd0) ||
                bus.ras_full !== (RAS_EN && i >= 7) || bus.ras_overflow !== (RAS_EN && i == 8)) begin
                $display("FAIL ovf_call_%0d pc=%h cnt=%0d full=%b ovf=%b want pc=%h",
                         i, bus.prog_cntr, bus.ras_count, bus.ras_full, bus.ras_overflow, tgt);
                errors++;
            end
        end
        for (int j = 0; j < 9; j++) begin
            exp = (RAS_EN && j < 8) ? 14'h1071 - 14'(j * 16) : 14'h0ABC;
            set_in(3'b011, 14'h0000);
            step();
            vectors++;
            if (bus.prog_cntr !== exp || bus.ras_underflow !== (RAS_EN && j == 8)) begin
                $display("FAIL ovf_ret_%0d pc=%h unf=%b want pc=%h unf=%b",
                         j, bus.prog_cntr, bus.ras_underflow, exp, RAS_EN && j == 8);
                errors++;
            end
        end
        // clear concurrent with another underflow: the set wins
        bus.clear_flags = 1'b1;
        step();
        vectors++;
        if (bus.ras_underflow !== RAS_EN || bus.ras_overflow !== 1'b0 || bus.ras_count !== 4'd0) begin
            $display("FAIL clear_vs_set unf=%b ovf=%b cnt=%0d want %b 0 0",
                     bus.ras_underflow, bus.ras_overflow, bus.ras_count, RAS_EN);
            errors++;
        end
        set_in(3'b101, 14'h0000);
        step();
        bus.clear_flags = 1'b0;
        vectors++;
        if (bus.ras_underflow !== 1'b0 || bus.ras_overflow !== 1'b0 || bus.prog_cntr !== 14'h0ABC) begin
            $display("FAIL clear_flags unf=%b ovf=%b pc=%h want 0 0 0ABC",
                     bus.ras_underflow, bus.ras_overflow, bus.prog_cntr);
            errors++;
        end
    endtask

    task automatic test_int();
        do_reset();
        set_in(3'b001, 14'h0050); step();
        bus.int_vector_addr = 14'h0004;
        set_in(3'b100, 14'h0777);
        step();
        vectors++;
        if (bus.prog_cntr !== 14'h0004 || bus.ras_count !== (RAS_EN ? 4'd1 : 4'd0)) begin
            $display("FAIL int_entry pc=%h cnt=%0d want 0004 %0d",
                     bus.prog_cntr, bus.ras_count, RAS_EN ? 1 : 0);
            errors++;
        end
        set_in(3'b011, 14'h0000);
        step();
        vectors++;
        if (bus.prog_cntr !== (RAS_EN ? 14'h0050 : 14'h0ABC) || bus.ras_count !== 4'd0) begin
            $display("FAIL int_ret pc=%h cnt=%0d want %h 0",
                     bus.prog_cntr, bus.ras_count, RAS_EN ? 14'h0050 : 14'h0ABC);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(3'b010, 14'h0400 + 14'(i));
            step();
        end
        vectors++;
        if (bus.ras_count !== (RAS_EN ? 4'd3 : 4'd0) || bus.prog_cntr !== 14'h0402) begin
            $display("FAIL pre_reset cnt=%0d pc=%h want %0d 0402",
                     bus.ras_count, bus.prog_cntr, RAS_EN ? 3 : 0);
            errors++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.prog_cntr !== 14'h0000 || bus.ras_empty !== 1'b1 || bus.ras_count !== 4'd0) begin
            $display("FAIL async_reset pc=%h empty=%b cnt=%0d want 0000 1 0",
                     bus.prog_cntr, bus.ras_empty, bus.ras_count);
            errors++;
        end
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.stall = 1'b0; bus.sel_signals = 3'b000; bus.clear_flags = 1'b0;
        bus.branch_target_addr = '0; bus.ret_addr = 14'h0ABC; bus.int_vector_addr = '0;
        #2;
        test_reset();
        test_wrap();
        test_call_ret();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_int();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
